serial_frame_receiver: RTL and testbench

Sits directly downstream of the quick_rs232 receive side and replaces ad-hoc per-byte echo handling. Drives the rx_read handshake, hunts for start-of-frame, and assembles LEN-prefixed frames with an XOR checksum into an internal buffer. After a good checksum it streams the payload to the application over a valid/ready byte interface. Bad frames are dropped and reported.

---
 rtl/serial_frame_receiver_pkg.sv | 31 +++
 rtl/serial_frame_receiver_if.sv | 21 ++
 rtl/serial_frame_receiver_byte_fetch.sv | 77 +++++++
 rtl/serial_frame_receiver.sv | 210 +++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and constants for the serial frame receiver: FSM encodings,
// drop-cause codes, the default start-of-frame marker and a saturating counter helper.
package serial_frame_receiver_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PARITY  = 2'd1,
        ERR_LENGTH  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } main_state_e;

    typedef enum logic {
        F_WAIT = 1'b0,
        F_ACK  = 1'b1
    } fetch_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Bus bundles: the byte link from the quick_rs232 receiver (master = UART side)
// and the payload byte stream towards the application (master = frame receiver).
interface rx_link_if;
    logic [7:0] rx_data;
    logic       rx_byte_received;
    logic       rx_err;
    logic       rx_read;

    modport master (output rx_data, output rx_byte_received, output rx_err, input rx_read);
    modport slave  (input rx_data, input rx_byte_received, input rx_err, output rx_read);
endinterface

interface byte_stream_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/serial_frame_receiver_byte_fetch.sv
// rx_read handshake towards quick_rs232: takes exactly one byte per
// rx_byte_received high period and hands it to the frame FSM with a one-cycle strobe.
module serial_byte_fetch
    import serial_frame_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    rx_link_if.slave   rx,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    fetch_state_e state_r, state_s;
    logic         rx_read_r, rx_read_s;
    logic         strobe_r, strobe_s;
    logic         err_r, err_s;
    logic [7:0]   data_r, data_s;

    // Next-state and handshake outputs; F_ACK always completes so rx_read never sticks high.
    always_comb begin
        state_s   = state_r;
        rx_read_s = rx_read_r;
        strobe_s  = 1'b0;
        data_s    = data_r;
        err_s     = err_r;
        case (state_r)
            F_WAIT: begin
                if (enable && rx.rx_byte_received) begin
                    state_s   = F_ACK;
                    rx_read_s = 1'b1;
                    strobe_s  = 1'b1;
                    data_s    = rx.rx_data;
                    err_s     = rx.rx_err;
                end else begin
                    rx_read_s = 1'b0;
                end
            end
            F_ACK: begin
                if (!rx.rx_byte_received) begin
                    state_s   = F_WAIT;
                    rx_read_s = 1'b0;
                end else begin
                    rx_read_s = 1'b1;
                end
            end
            default: begin
                state_s   = F_WAIT;
                rx_read_s = 1'b0;
            end
        endcase
    end

    // Fetch state and latched byte registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= F_WAIT;
            rx_read_r <= 1'b0;
            strobe_r  <= 1'b0;
            data_r    <= 8'h00;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            rx_read_r <= rx_read_s;
            strobe_r  <= strobe_s;
            data_r    <= data_s;
            err_r     <= err_s;
        end
    end

    assign rx.rx_read  = rx_read_r;
    assign byte_strobe = strobe_r;
    assign byte_data   = data_r;
    assign byte_err    = err_r;

endmodule

// File: rtl/serial_frame_receiver.sv
// Frame assembler: hunts for SOF, collects LEN-prefixed payload with XOR checksum,
// streams good frames out over valid/ready and reports dropped frames.
module serial_frame_receiver
    import serial_frame_receiver_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 5000000
) (
    input  logic          clk,
    input  logic          rst,
    rx_link_if.slave      rx,
    byte_stream_if.master stream,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic [15:0]   frames_ok,
    output logic [15:0]   frames_bad
);

    localparam int               LEN_W     = $clog2(MAX_PAYLOAD + 1);
    localparam int               IDX_W     = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    main_state_e      state_r, state_s;
    logic             byte_strobe_s, byte_err_s, fetch_en_s;
    logic [7:0]       byte_data_s;
    logic [LEN_W-1:0] len_r, len_s, wr_idx_r, wr_idx_s, rd_idx_r, rd_idx_s;
    logic [LEN_W-1:0] wr_next_s, rd_next_s;
    logic [7:0]       csum_r, csum_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [7:0]       buf_r [MAX_PAYLOAD];
    logic             buf_we_s;
    logic             out_valid_r, out_valid_s, out_last_r, out_last_s;
    logic [7:0]       out_data_r, out_data_s;
    logic             frame_err_r, frame_err_s;
    err_code_e        err_code_r, err_code_s, drop_code_s;
    logic [15:0]      frames_ok_r, frames_ok_s, frames_bad_r, frames_bad_s;
    logic             drop_s, in_frame_s, timeout_s;

    // Bytes stay in the UART FIFO while a frame is being delivered.
    assign fetch_en_s = (state_r != DRAIN);

    serial_byte_fetch u_fetch (
        .clk         (clk),
        .rst         (rst),
        .enable      (fetch_en_s),
        .rx          (rx),
        .byte_strobe (byte_strobe_s),
        .byte_data   (byte_data_s),
        .byte_err    (byte_err_s)
    );

    assign wr_next_s  = wr_idx_r + LEN_ONE;
    assign rd_next_s  = rd_idx_r + LEN_ONE;
    assign in_frame_s = (state_r == LEN) || (state_r == PAYLOAD) || (state_r == CSUM);
    // timer_r counts cycles elapsed since the last strobe, so a drop lands exactly TIMEOUT_CYCLES later.
    assign timeout_s  = in_frame_s && (timer_r == TMR_LAST);

    // Main frame FSM next-state, datapath and status updates; timeout outranks a same-cycle byte.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        wr_idx_s     = wr_idx_r;
        rd_idx_s     = rd_idx_r;
        csum_s       = csum_r;
        timer_s      = in_frame_s ? (timer_r + TMR_ONE) : timer_r;
        buf_we_s     = 1'b0;
        out_valid_s  = out_valid_r;
        out_last_s   = out_last_r;
        out_data_s   = out_data_r;
        frame_err_s  = 1'b0;
        err_code_s   = err_code_r;
        frames_ok_s  = frames_ok_r;
        frames_bad_s = frames_bad_r;
        drop_s       = 1'b0;
        drop_code_s  = ERR_NONE;
        case (state_r)
            HUNT: begin
                if (byte_strobe_s && !byte_err_s && (byte_data_s == SOF_BYTE)) begin
                    state_s  = LEN;
                    csum_s   = 8'h00;
                    wr_idx_s = LEN_ZERO;
                    timer_s  = TMR_ONE;
                end else begin
                    state_s = HUNT;
                end
            end
            LEN, PAYLOAD, CSUM: begin
                if (timeout_s) begin
                    drop_s      = 1'b1;
                    drop_code_s = ERR_TIMEOUT;
                end else if (byte_strobe_s) begin
                    timer_s = TMR_ONE;
                    if (byte_err_s) begin
                        drop_s      = 1'b1;
                        drop_code_s = ERR_PARITY;
                    end else if (state_r == LEN) begin
                        csum_s = csum_r ^ byte_data_s;
                        if ((byte_data_s == 8'h00) || (byte_data_s > MAX_LEN_B)) begin
                            drop_s      = 1'b1;
                            drop_code_s = ERR_LENGTH;
                        end else begin
                            len_s   = byte_data_s[LEN_W-1:0];
                            state_s = PAYLOAD;
                        end
                    end else if (state_r == PAYLOAD) begin
                        buf_we_s = 1'b1;
                        csum_s   = csum_r ^ byte_data_s;
                        wr_idx_s = wr_next_s;
                        state_s  = (wr_next_s == len_r) ? CSUM : PAYLOAD;
                    end else if (byte_data_s == csum_r) begin
                        state_s     = DRAIN;
                        rd_idx_s    = LEN_ZERO;
                        out_valid_s = 1'b1;
                        out_data_s  = buf_r[0];
                        out_last_s  = (len_r == LEN_ONE);
                        frames_ok_s = sat_inc16(frames_ok_r);
                    end else begin
                        drop_s      = 1'b1;
                        drop_code_s = ERR_LENGTH;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DRAIN: begin
                if (out_valid_r && stream.out_ready) begin
                    if (out_last_r) begin
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        state_s     = HUNT;
                    end else begin
                        rd_idx_s   = rd_next_s;
                        out_data_s = buf_r[rd_next_s[IDX_W-1:0]];
                        out_last_s = (rd_next_s == (len_r - LEN_ONE));
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s     = HUNT;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
        if (drop_s) begin
            state_s      = HUNT;
            frame_err_s  = 1'b1;
            err_code_s   = drop_code_s;
            frames_bad_s = sat_inc16(frames_bad_r);
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Main FSM, datapath and registered output state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= HUNT;
            len_r        <= LEN_ZERO;
            wr_idx_r     <= LEN_ZERO;
            rd_idx_r     <= LEN_ZERO;
            csum_r       <= 8'h00;
            timer_r      <= {TMR_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= 8'h00;
            frame_err_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
            frames_ok_r  <= 16'h0000;
            frames_bad_r <= 16'h0000;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            wr_idx_r     <= wr_idx_s;
            rd_idx_r     <= rd_idx_s;
            csum_r       <= csum_s;
            timer_r      <= timer_s;
            out_valid_r  <= out_valid_s;
            out_last_r   <= out_last_s;
            out_data_r   <= out_data_s;
            frame_err_r  <= frame_err_s;
            err_code_r   <= err_code_s;
            frames_ok_r  <= frames_ok_s;
            frames_bad_r <= frames_bad_s;
        end
    end

    // Payload buffer; contents are only read after being written by the current frame.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_r[wr_idx_r[IDX_W-1:0]] <= byte_data_s;
        end
    end

    assign stream.out_valid = out_valid_r;
    assign stream.out_last  = out_last_r;
    assign stream.out_data  = out_data_r;
    assign frame_err        = frame_err_r;
    assign err_code         = err_code_r;
    assign frames_ok        = frames_ok_r;
    assign frames_bad       = frames_bad_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: UART-side byte handshake model,
// payload scoreboard and drop/timing checks.
module tb_serial_frame_receiver;
    import serial_frame_receiver_pkg::*;

    localparam int TMO   = 100;
    localparam int BOUND = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_link_if     rx_bus ();
    byte_stream_if out_bus ();
    logic          frame_err;
    logic [1:0]    err_code;
    logic [15:0]   frames_ok, frames_bad;

    serial_frame_receiver #(
        .MAX_PAYLOAD    (16),
        .SOF_BYTE       (8'hAA),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_bus),
        .stream     (out_bus),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         ack_cyc = 0;
    int         err_cyc = 0;
    int         err_pulses = 0;
    int         vrise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [8:0] exp_q [$];
    logic [7:0] tx_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every accepted payload byte is popped from the scoreboard.
    always @(negedge clk) begin
        logic [31:0] exp32;
        if (frame_err === 1'b1) begin
            err_pulses++;
            err_cyc = cyc;
        end
        if (out_bus.out_valid && !prev_valid) vrise_cyc = cyc;
        prev_valid = out_bus.out_valid;
        if (out_bus.out_valid && out_bus.out_ready) begin
            exp32 = (exp_q.size() != 0) ? {23'd0, exp_q.pop_front()} : 32'hDEAD0000;
            check("out_byte", {23'd0, out_bus.out_last, out_bus.out_data}, exp32);
        end
    end

    task automatic present(input logic [7:0] b, input logic e);
        @(posedge clk); #1;
        rx_bus.rx_data          = b;
        rx_bus.rx_err           = e;
        rx_bus.rx_byte_received = 1'b1;
    endtask

    task automatic wait_ack(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (rx_bus.rx_read) begin
                seen    = 1'b1;
                ack_cyc = cyc;
            end
        end
        check("rx_read_rise", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rx_bus.rx_byte_received = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (!rx_bus.rx_read) seen = 1'b1;
        end
        check("rx_read_fall", 32'(seen), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        present(b, e);
        wait_ack(BOUND);
    endtask

    task automatic add_csum();
        logic [7:0] c = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) c ^= tx_q[i];
        tx_q.push_back(c);
    endtask

    // Sends tx_q; a good frame (AA LEN payload CSUM) queues its payload as expected output.
    task automatic send_frame(input bit good);
        if (good) begin
            for (int i = 2; i < tx_q.size() - 1; i++)
                exp_q.push_back({(i == tx_q.size() - 2), tx_q[i]});
        end
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0);
        tx_q.delete();
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < BOUND && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_bus.out_valid) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        bit moved, read_seen, dropped, got;
        int pulses0;
        rx_bus.rx_data = 8'h00; rx_bus.rx_err = 1'b0; rx_bus.rx_byte_received = 1'b0;
        out_bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_read", 32'(rx_bus.rx_read), 32'd0);
        check("rst_out_valid", 32'(out_bus.out_valid), 32'd0);
        check("rst_out_last", 32'(out_bus.out_last), 32'd0);
        check("rst_out_data", 32'(out_bus.out_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_frames_ok", 32'(frames_ok), 32'd0);
        check("rst_frames_bad", 32'(frames_bad), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Good frame; XOR over LEN and payload gives 03.
        tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33}; add_csum();
        check("good_csum_value", 32'(tx_q[5]), 32'h03);
        send_frame(1'b1);
        check("good_latency", 32'(vrise_cyc - ack_cyc), 32'd1);
        wait_drain();
        check("good_frames_ok", 32'(frames_ok), 32'd1);
        check("good_no_err", 32'(err_pulses), 32'd0);

        // Bad checksum.
        tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01}; send_frame(1'b0);
        repeat (3) @(negedge clk);
        check("badcs_pulses", 32'(err_pulses), 32'd1);
        check("badcs_code", 32'(err_code), 32'(ERR_LENGTH));
        check("badcs_frames_bad", 32'(frames_bad), 32'd1);
        check("badcs_frames_ok", 32'(frames_ok), 32'd1);

        // Noise before SOF; only 7E delivered.
        exp_q.push_back({1'b1, 8'h7E});
        tx_q = '{8'h55, 8'h00, 8'hAA, 8'h01, 8'h7E, 8'h7F}; send_frame(1'b0);
        wait_drain();
        check("noise_frames_ok", 32'(frames_ok), 32'd2);
        check("noise_no_err", 32'(err_pulses), 32'd1);

        // LEN = 0.
        tx_q = '{8'hAA, 8'h00}; send_frame(1'b0);
        repeat (2) @(negedge clk);
        check("len0_delay", 32'(err_cyc - ack_cyc), 32'd1);
        check("len0_code", 32'(err_code), 32'(ERR_LENGTH));
        check("len0_frames_bad", 32'(frames_bad), 32'd2);

        // Errored SOF ignored in HUNT, errored payload byte drops the frame.
        send_byte(8'hAA, 1'b1);
        check("hunt_err_ignored", 32'(err_pulses), 32'd2);
        send_byte(8'hAA, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h10, 1'b1);
        repeat (2) @(negedge clk);
        check("parity_code", 32'(err_code), 32'(ERR_PARITY));
        check("parity_frames_bad", 32'(frames_bad), 32'd3);
        check("parity_pulses", 32'(err_pulses), 32'd3);

        // LEN 17 > MAX_PAYLOAD, then a good frame.
        tx_q = '{8'hAA, 8'h11}; send_frame(1'b0);
        repeat (2) @(negedge clk);
        check("len17_delay", 32'(err_cyc - ack_cyc), 32'd1);
        check("len17_code", 32'(err_code), 32'(ERR_LENGTH));
        check("len17_frames_bad", 32'(frames_bad), 32'd4);
        tx_q = '{8'hAA, 8'h02, 8'h5A, 8'hA5}; add_csum(); send_frame(1'b1);
        wait_drain();
        check("after17_frames_ok", 32'(frames_ok), 32'd3);

        // Timeout after two payload bytes.
        pulses0 = err_pulses;
        tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22}; send_frame(1'b0);
        got = 1'b0;
        for (int i = 0; i < BOUND && !got; i++) begin
            @(negedge clk);
            if (err_pulses != pulses0) got = 1'b1;
        end
        check("tmo_seen", 32'(got), 32'd1);
        check("tmo_delay", 32'(err_cyc - ack_cyc), 32'(TMO));
        check("tmo_code", 32'(err_code), 32'(ERR_TIMEOUT));
        check("tmo_frames_bad", 32'(frames_bad), 32'd5);
        check("tmo_frames_ok", 32'(frames_ok), 32'd3);

        // Backpressure with the next frame's SOF pending.
        @(posedge clk); #1; out_bus.out_ready = 1'b0;
        tx_q = '{8'hAA, 8'h02, 8'hC3, 8'h3C}; add_csum(); send_frame(1'b1);
        @(negedge clk);
        check("bp_valid", 32'(out_bus.out_valid), 32'd1);
        held = out_bus.out_data;
        moved = 1'b0; read_seen = 1'b0; dropped = 1'b0;
        present(8'hAA, 1'b0);
        repeat (50) begin
            @(negedge clk);
            if (out_bus.out_data !== held) moved = 1'b1;
            if (rx_bus.rx_read) read_seen = 1'b1;
            if (!out_bus.out_valid) dropped = 1'b1;
        end
        check("bp_data_first", 32'(held), 32'hC3);
        check("bp_data_stable", 32'(moved), 32'd0);
        check("bp_no_rx_read", 32'(read_seen), 32'd0);
        check("bp_valid_held", 32'(dropped), 32'd0);
        @(posedge clk); #1; out_bus.out_ready = 1'b1;
        wait_ack(BOUND);
        exp_q.push_back({1'b1, 8'h99});
        send_byte(8'h01, 1'b0); send_byte(8'h99, 1'b0); send_byte(8'h98, 1'b0);
        wait_drain();
        check("bp_frames_ok", 32'(frames_ok), 32'd5);

        // Reset in the middle of a payload.
        tx_q = '{8'hAA, 8'h04, 8'h01, 8'h02}; send_frame(1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_out_valid", 32'(out_bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_bus.out_data), 32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        check("mid_rst_frames_ok", 32'(frames_ok), 32'd0);
        check("mid_rst_frames_bad", 32'(frames_bad), 32'd0);
        check("mid_rst_rx_read", 32'(rx_bus.rx_read), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        tx_q = '{8'hAA, 8'h01, 8'h42}; add_csum(); send_frame(1'b1);
        wait_drain();
        check("post_rst_frames_ok", 32'(frames_ok), 32'd1);
        check("post_rst_frames_bad", 32'(frames_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
